// File: rtl/md_sched_if.sv
// md_sched_if: E-stage md-class request and HI/LO result bundle between pipeline and md_sched.
interface md_sched_if;
    logic [3:0]  E_op;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_md;
    logic        busy;
    logic        stall;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    modport master (output E_op, E_A, E_B, D_md, input busy, stall, md_out, hi, lo, done);
    modport slave  (input E_op, E_A, E_B, D_md, output busy, stall, md_out, hi, lo, done);
endinterface

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer owning HI/LO; result is computed at launch and
// committed after a fixed busy latency, modelling a multi-cycle unit.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    md_sched_if.slave md
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MTHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MFHI  = 4'd8;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        dz_q, dz_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;
    logic        start, is_mul, is_div, b_zero;
    logic signed [31:0] a_s, dv_s, q_s, r_s;
    logic [31:0] dv_u, q_u, r_u;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u, launch_res;
    assign start  = (md.E_op >= OP_MULT) && (md.E_op <= OP_DIVU);
    assign is_mul = (md.E_op == OP_MULT) || (md.E_op == OP_MULTU);
    assign is_div = (md.E_op == OP_DIV) || (md.E_op == OP_DIVU);
    assign b_zero = (md.E_B == 32'd0);
    // A zero divisor is swapped for 1 so the arithmetic stays defined; its result is discarded.
    assign a_s    = $signed(md.E_A);
    assign dv_u   = b_zero ? 32'd1 : md.E_B;
    assign dv_s   = $signed(dv_u);
    assign q_s    = a_s / dv_s;
    assign r_s    = a_s % dv_s;
    assign q_u    = md.E_A / dv_u;
    assign r_u    = md.E_A % dv_u;
    assign prod_s = $signed({{32{md.E_A[31]}}, md.E_A}) * $signed({{32{md.E_B[31]}}, md.E_B});
    assign prod_u = {32'd0, md.E_A} * {32'd0, md.E_B};
    assign launch_res = (md.E_op == OP_MULT)  ? prod_s :
                        (md.E_op == OP_MULTU) ? prod_u :
                        (md.E_op == OP_DIV)   ? {r_s, q_s} : {r_u, q_u};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = RUN;
                cnt_d   = is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                res_d   = launch_res;
                dz_d    = is_div & b_zero;
            end else if (md.E_op == OP_MTHI) begin
                hi_d = md.E_A;
            end else if (md.E_op == OP_MTLO) begin
                lo_d = md.E_A;
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
                done_d  = 1'b1;
                hi_d    = dz_q ? hi_q : res_q[63:32];
                lo_d    = dz_q ? lo_q : res_q[31:0];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            res_q   <= 64'd0;
            dz_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign md.busy   = (state_q == RUN);
    assign md.stall  = md.D_md & (md.busy | start);
    assign md.md_out = (md.E_op == OP_MFHI) ? hi_q : (md.E_op == OP_MFLO) ? lo_q : 32'd0;
    assign md.hi     = hi_q;
    assign md.lo     = lo_q;
    assign md.done   = done_q;
endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed checks of md_sched latency, HI/LO results, stall and reset abort.
module tb_md_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    md_sched_if bus ();
    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(bus.slave));
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Launch from IDLE, then watch busy/stall for n cycles and check the commit.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic dmd, input logic [31:0] eh, input logic [31:0] el);
        bus.E_op = op; bus.E_A = a; bus.E_B = b; bus.D_md = dmd;
        #1;
        chk("launch_stall", 32'(bus.stall), 32'(dmd));
        step();
        bus.E_op = 4'd0;
        for (int i = 0; i < n; i++) begin
            chk("busy", 32'(bus.busy), 32'd1);
            chk("run_stall", 32'(bus.stall), 32'(dmd));
            chk("done_early", 32'(bus.done), 32'd0);
            step();
        end
        chk("busy_end", 32'(bus.busy), 32'd0);
        chk("done", 32'(bus.done), 32'd1);
        chk("stall_end", 32'(bus.stall), 32'd0);
        chk("hi", bus.hi, eh);
        chk("lo", bus.lo, el);
    endtask
    always @(negedge clk)
        if (!reset && bus.busy)
            assert (!(bus.E_op >= 4'd1 && bus.E_op <= 4'd6)) else begin
                bad++;
                $error("FAIL op_while_busy observed=%h expected=none", bus.E_op);
            end
    initial begin
        bus.E_op = 4'd0; bus.E_A = 32'd0; bus.E_B = 32'd0; bus.D_md = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        run_op(4'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA);
        step();
        chk("done_fall", 32'(bus.done), 32'd0);
        run_op(4'd2, 32'hFFFFFFFF, 32'd2, 5, 1'b0, 32'h00000001, 32'hFFFFFFFE);
        // Launch directly in the done cycle to cover back-to-back issue.
        run_op(4'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD);
        step();
        run_op(4'd4, 32'd7, 32'd0, 10, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        step();
        run_op(4'd4, 32'd100, 32'd7, 10, 1'b0, 32'd2, 32'd14);
        step();
        bus.E_op = 4'd6; bus.E_A = 32'h12345678;
        step();
        chk("mthi_busy", 32'(bus.busy), 32'd0);
        chk("mthi_hi", bus.hi, 32'h12345678);
        chk("mthi_lo_keep", bus.lo, 32'd14);
        bus.E_op = 4'd8;
        #1;
        chk("mfhi", bus.md_out, 32'h12345678);
        bus.E_op = 4'd5; bus.E_A = 32'hCAFEF00D;
        #1;
        chk("md_out_idle", bus.md_out, 32'd0);
        step();
        bus.E_op = 4'd7;
        #1;
        chk("mflo", bus.md_out, 32'hCAFEF00D);
        chk("mtlo_hi_keep", bus.hi, 32'h12345678);
        bus.E_op = 4'd0; bus.D_md = 1'b1;
        #1;
        chk("idle_stall", 32'(bus.stall), 32'd0);
        bus.D_md = 1'b0;
        bus.E_op = 4'd3; bus.E_A = 32'd100; bus.E_B = 32'd3;
        step();
        bus.E_op = 4'd0;
        step();
        step();
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_quiet", {30'd0, bus.busy, bus.done}, 32'd0);
        end
        chk("abort_lo_final", bus.lo, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
